// File: rtl/cnn_pkg.sv
// Shared fp32 helpers for the CNN activation/pooling stages.
// Every operand reaching fp_max_nonneg has already been through fp_relu.
package cnn_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int FP_SIGN_BIT = 31;

  typedef logic [DATA_WIDTH-1:0] fp_t;

  localparam fp_t FP_ZERO = '0;

  // Any value with the sign bit set, including -0, -inf and negative NaN, becomes +0.
  function automatic fp_t fp_relu(input fp_t x);
    return x[FP_SIGN_BIT] ? FP_ZERO : x;
  endfunction

  // For non-negative fp32 values an unsigned compare of the bit patterns orders them,
  // so a positive NaN wins every compare.
  function automatic fp_t fp_max_nonneg(input fp_t a, input fp_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/fp_relu_max2.sv
// ReLU on operand b, then the larger of a and relu(b).
// Operand a must already be non-negative.
module fp_relu_max2
  import cnn_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_y
);
  always_comb o_y = fp_max_nonneg(i_a, fp_relu(i_b));
endmodule

// File: rtl/relu_maxpool_stream.sv
// Streaming ReLU followed by 2x2/stride-2 max pooling on a raster fp32 pixel stream.
// A half-width line buffer holds the pair maxima of each even row.
module relu_maxpool_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int INPUT      = 30,
  parameter int FILTERS    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);
  localparam int OUTPUT = INPUT / 2;
  localparam int CW     = (INPUT   > 1) ? $clog2(INPUT)   : 1;
  localparam int PW     = (FILTERS > 1) ? $clog2(FILTERS) : 1;
  localparam int LW     = (OUTPUT  > 1) ? $clog2(OUTPUT)  : 1;

  logic [CW-1:0]         r_col, r_row;
  logic [PW-1:0]         r_plane;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [DATA_WIDTH-1:0] r_lb [OUTPUT];
  logic                  r_out_valid, r_out_last;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic                  w_acc, w_col_end, w_row_end, w_plane_end, w_last_win;
  logic                  w_lb_wr, w_pool_ld;
  logic [LW-1:0]         w_lb_idx;
  logic [DATA_WIDTH-1:0] w_lb_rd, w_pair, w_pool;

  assign in_ready  = !r_out_valid || out_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;

  assign w_acc       = in_valid && in_ready;
  assign w_col_end   = (r_col   == CW'(INPUT - 1));
  assign w_row_end   = (r_row   == CW'(INPUT - 1));
  assign w_plane_end = (r_plane == PW'(FILTERS - 1));
  assign w_last_win  = (r_row == CW'(2*OUTPUT - 1)) && (r_col == CW'(2*OUTPUT - 1)) && w_plane_end;

  // Odd columns only: the trailing column of an odd-width plane never touches the buffer.
  assign w_lb_idx  = LW'(r_col >> 1);
  assign w_lb_rd   = r_lb[w_lb_idx];
  assign w_lb_wr   = w_acc && r_col[0] && !r_row[0];
  assign w_pool_ld = w_acc && r_col[0] &&  r_row[0];

  fp_relu_max2 u_pair (.i_a(r_hold),  .i_b(in_data), .o_y(w_pair));
  fp_relu_max2 u_row  (.i_a(w_lb_rd), .i_b(w_pair),  .o_y(w_pool));

  always_ff @(posedge clk) begin
    if (w_lb_wr) r_lb[w_lb_idx] <= w_pair;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_plane     <= '0;
      r_hold      <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      if (w_acc) begin
        if (!r_col[0]) r_hold <= fp_relu(in_data);
        if (w_col_end) begin
          r_col <= '0;
          if (w_row_end) begin
            r_row   <= '0;
            r_plane <= w_plane_end ? '0 : r_plane + 1'b1;
          end else begin
            r_row <= r_row + 1'b1;
          end
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      // A new window result takes the register even while the old one drains.
      if (w_pool_ld) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_pool;
        r_out_last  <= w_last_win;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_relu_maxpool_stream.sv
// Scoreboard bench: an even-width instance (4x4, 2 planes) and an odd-width instance (5x5, 1 plane).
// Expected windows are queued as planes are driven and popped on each output handshake.
module tb_relu_maxpool_stream;
  localparam int NA = 4, FA = 2;
  localparam int NB = 5, FB = 1;

  logic        clk = 1'b0, rst = 1'b1;
  logic        a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b1, a_out_last;
  logic [31:0] a_in_data = '0, a_out_data;
  logic        b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b1, b_out_last;
  logic [31:0] b_in_data = '0, b_out_data;

  int          n_cmp = 0, n_err = 0, a_lastcnt = 0, b_lastcnt = 0, pa = 0;
  logic [32:0] qa[$], qb[$];
  logic [32:0] ea, eb;
  logic [31:0] pbuf [25];
  logic [31:0] t1v [16] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
                            32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
                            32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
  logic [31:0] held;

  always #5 clk = ~clk;

  relu_maxpool_stream #(.DATA_WIDTH(32), .INPUT(NA), .FILTERS(FA)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_last(a_out_last));

  relu_maxpool_stream #(.DATA_WIDTH(32), .INPUT(NB), .FILTERS(FB)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_last(b_out_last));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mrelu(input logic [31:0] x);
    return x[31] ? 32'h0 : x;
  endfunction

  function automatic logic [31:0] mmax(input logic [31:0] x, input logic [31:0] y);
    return (x > y) ? x : y;
  endfunction

  always @(negedge clk) begin
    if (!rst && a_out_valid && a_out_ready) begin
      chk("a_qnonempty", qa.size() > 0, 1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        chk("a_data", a_out_data, ea[31:0]);
        chk("a_last", a_out_last, ea[32]);
      end
      if (a_out_last) a_lastcnt++;
    end
    if (!rst && b_out_valid && b_out_ready) begin
      chk("b_qnonempty", qb.size() > 0, 1);
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        chk("b_data", b_out_data, eb[31:0]);
        chk("b_last", b_out_last, eb[32]);
      end
      if (b_out_last) b_lastcnt++;
    end
  end

  // All tasks start and end at posedge+1.
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input bit b, input logic [31:0] px, input int gap);
    bit ok = 1'b0;
    int k  = 0;
    repeat (gap) begin
      if (b) b_in_valid = 1'b0; else a_in_valid = 1'b0;
      @(posedge clk); #1;
    end
    if (b) begin b_in_valid = 1'b1; b_in_data = px; end
    else   begin a_in_valid = 1'b1; a_in_data = px; end
    while (!ok && k < 100) begin
      @(negedge clk);
      ok = b ? b_in_ready : a_in_ready;
      @(posedge clk); #1;
      k++;
    end
    chk(b ? "b_accept" : "a_accept", ok, 1);
    if (b) b_in_valid = 1'b0; else a_in_valid = 1'b0;
  endtask

  task automatic plane(input bit b, input int gmax);
    int n = b ? NB : NA;
    int o = n / 2;
    int base;
    logic [31:0] m;
    bit last;
    for (int r = 0; r < o; r++)
      for (int c = 0; c < o; c++) begin
        base = 2*r*n + 2*c;
        m = mmax(mmax(mrelu(pbuf[base]),   mrelu(pbuf[base+1])),
                 mmax(mrelu(pbuf[base+n]), mrelu(pbuf[base+n+1])));
        last = (r == o-1) && (c == o-1) && (b ? 1'b1 : (pa == FA-1));
        if (b) qb.push_back({last, m}); else qa.push_back({last, m});
      end
    for (int i = 0; i < n*n; i++)
      send(b, pbuf[i], (gmax > 0) ? int'($urandom_range(0, gmax)) : 0);
    if (!b) pa = (pa + 1) % FA;
  endtask

  task automatic fill_rand(input bit pos_only);
    for (int i = 0; i < 25; i++) begin
      pbuf[i] = $urandom();
      if (pos_only) pbuf[i][31] = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_a_valid", a_out_valid, 0);
    chk("rst_a_data",  a_out_data,  0);
    chk("rst_a_last",  a_out_last,  0);
    chk("rst_a_ready", a_in_ready,  1);
    chk("rst_b_valid", b_out_valid, 0);
    chk("rst_b_data",  b_out_data,  0);
    chk("rst_b_ready", b_in_ready,  1);
    @(posedge clk); #1;

    // 1.0..16.0 ramp; first window completes on the 6th accepted pixel
    for (int i = 0; i < 16; i++) pbuf[i] = t1v[i];
    fork
      plane(0, 0);
      begin
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("t1_lat_before", a_out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk("t1_lat_valid", a_out_valid, 1);
        chk("t1_first",     a_out_data,  32'h40C00000);
      end
    join

    // negatives, -0, -inf, -NaN all clamp to +0
    for (int i = 0; i < 16; i++) pbuf[i] = 32'hBF800000;
    pbuf[0] = 32'h80000000; pbuf[1] = 32'hFF800000;
    pbuf[4] = 32'hFFC00000; pbuf[5] = 32'hC0000000;
    plane(0, 0);

    // odd width: trailing column/row discarded, next plane stays aligned
    for (int i = 0; i < 25; i++) pbuf[i] = 32'(i + 1);
    plane(1, 0);
    plane(1, 0);

    // stall the output mid-plane while input keeps offering
    fill_rand(1'b1);
    fork
      plane(0, 0);
      begin
        int k = 0;
        repeat (5) @(posedge clk);
        #1 a_out_ready = 1'b0;
        @(negedge clk);
        while (!a_out_valid && k < 50) begin @(negedge clk); k++; end
        chk("t4_stalled_valid", a_out_valid, 1);
        held = a_out_data;
        repeat (5) begin
          @(negedge clk);
          chk("t4_in_ready", a_in_ready,  0);
          chk("t4_valid",    a_out_valid, 1);
          chk("t4_hold",     a_out_data,  held);
        end
        @(posedge clk); #1 a_out_ready = 1'b1;
      end
    join
    fill_rand(1'b0);
    plane(0, 3);

    // two more frames with random input gaps and full-range bit patterns
    repeat (4) begin fill_rand(1'b0); plane(0, 3); end
    idle(4);

    // reset mid-row of plane 1 with an output pending
    fill_rand(1'b0);
    plane(0, 0);
    idle(2);
    a_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) send(0, $urandom(), 0);
    @(negedge clk);
    chk("t6_pending", a_out_valid, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    pa = 0;
    @(negedge clk);
    chk("t6_valid", a_out_valid, 0);
    chk("t6_data",  a_out_data,  0);
    chk("t6_last",  a_out_last,  0);
    chk("t6_ready", a_in_ready,  1);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    fill_rand(1'b0); plane(0, 2);
    fill_rand(1'b0); plane(0, 2);

    idle(10);
    chk("a_drained",   qa.size(), 0);
    chk("b_drained",   qb.size(), 0);
    chk("a_last_cnt",  a_lastcnt, 5);
    chk("b_last_cnt",  b_lastcnt, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
